intc_sched: RTL and testbench
=============================

Name: intc_sched

Overview:
- Prioritising interrupt controller between the peripheral IRQ lines (timer, UART, keys, …) and the CPU hardware-interrupt input.
- Synchronises and latches up to NSRC requests, applies mask and edge/level mode, and presents one request at a time to the CPU.
- Lower source index = higher priority.
- Sits behind the bridge as a memory-mapped device: the handler reads VEC to acknowledge and writes VEC to signal end-of-interrupt (EOI).

Parameters:
NSRC, 6, number of interrupt sources (1..31)
SYNC_STAGES, 2, synchroniser flops per source (>=2)

Ports:
clk  in  1  system clock
sys_rstn  in  1  asynchronous active-low reset
src  in  NSRC  raw interrupt request lines from devices
addr  in  2  register word select (bus address bits [3:2])
sel  in  1  device select from bridge
we  in  1  write enable (valid with sel)
wd  in  32  write data
rd  out  32  read data, combinational from addr
irq  out  1  interrupt request to CPU

Behaviour:
- Reset:
  - Asynchronous, active low; clk is the only clock.
  - Reset values: pend=0, mask=0, edge={NSRC{1}}, state=IDLE, cur_id=0, irq=0, synchronisers=0.
  - Reset asserted mid-service returns to IDLE immediately; no EOI is needed afterwards.
- Register map (word addresses):
  - 0 PEND: RO. Write-1-to-clear, edge sources only.
  - 1 MASK: RW. 1 = enabled.
  - 2 EDGE: RW. 1 = rising-edge triggered, 0 = level.
  - 3 VEC:
    - Read: bit31=valid, [4:0]=source id, others 0.
    - Write (any data): EOI.
  - Bits at or above NSRC read 0 and ignore writes.
- Source capture:
  - Each src passes through SYNC_STAGES flops.
  - Edge mode: pend[i] sets on a 0->1 transition of the synchronised line.
  - Level mode: pend[i] = synchronised level every cycle. W1C has no effect.
  - Edge set and clear (W1C or ack) in the same cycle: set wins.
- Definitions:
  - elig = pend & mask.
  - top = lowest set index of elig.
- FSM:
  - IDLE:
    - irq=0.
    - elig!=0 -> ASSERT next cycle.
    - Latency from src rising to irq=1 is SYNC_STAGES+2 cycles.
  - ASSERT:
    - irq=1.
    - If elig becomes 0 (masked or W1C) -> IDLE, irq drops next cycle.
    - On VEC read (sel & ~we & addr==3) at the clock edge -> INSERV.
    - The ack latches cur_id=top and clears pend[top] if edge mode.
    - rd during that read shows {1, top}.
  - INSERV:
    - irq=0.
    - VEC read returns {1, cur_id} and has no side effect.
    - VEC write (EOI) -> IDLE.
    - A level source still asserted re-requests 1 cycle later via IDLE.
- VEC read in IDLE returns 0 (valid=0) with no side effect.
- EOI in IDLE or ASSERT is ignored.
- Register writes take effect at the clock edge. A MASK write and a VEC read in the same cycle are impossible (single bus).
- No arithmetic beyond the priority encoder; id width is 5 bits, zero-extended.

Optional Feature:
- Macro: INTC_NEST_EN.
- Defined:
  - cur_id is replaced by an NSRC-bit in-service vector isv.
  - In INSERV, if top exists and top < lowest set index of isv, irq reasserts (state ASSERT) and allows a preempting ack.
  - Each ack sets isv[top].
  - EOI clears the lowest set bit of isv; FSM returns to IDLE only when isv becomes 0, otherwise stays INSERV.
  - VEC read in INSERV returns the highest-priority in-service id.
- Undefined:
  - Single-level service as above; no preemption.

Test Plan:
- Reset, then MASK=0x3F, pulse src[3] for 1 cycle -> PEND=0x08 after 2 cycles, irq=1 on the following cycle; VEC read=0x80000003; PEND=0, irq=0; EOI -> IDLE, irq stays 0.
- Raise src[4] and src[1] on the same cycle (edge mode) -> VEC read returns id 1; after EOI irq reasserts and VEC returns id 4.
- EDGE=0, hold src[2] high, ack + EOI -> irq reasserts within 2 cycles; drop src[2] -> PEND bit 2 reads 0, irq stays 0.
- MASK=0, pulse src[0] -> PEND=0x01, irq=0; write MASK=0x01 -> irq=1 two cycles later; write PEND=0x01 in ASSERT -> irq=0 next cycle.
- Assert sys_rstn=0 while INSERV -> irq=0, MASK=0, VEC reads 0 immediately; after release, src pulse is ignored until MASK is written.
- (INTC_NEST_EN) Ack id 4, then pulse src[0] -> irq=1, VEC=0x80000000; EOI -> VEC=0x80000004, irq=0; second EOI -> IDLE.

Source files
------------

// File: rtl/intc_sched_if.sv
// Bus and IRQ bundle for intc_sched: peripheral request lines, the bridge register port,
// the CPU interrupt line and a read-only view of the controller state.
interface intc_sched_if #(
  parameter int NSRC = 6
);
  logic [NSRC-1:0] src;
  logic [1:0]      addr;
  logic            sel;
  logic            we;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic            irq;
  logic [1:0]      dbg_state;

  // Register port: an access is a single cycle with sel high and no wait states. rd is
  // combinational from addr; writes and the VEC-read acknowledge commit at the clock edge
  // that ends the sel cycle.
  modport slave (
    input  src, addr, sel, we, wd,
    output rd, irq, dbg_state
  );
  modport master (
    output src, addr, sel, we, wd,
    input  rd, irq, dbg_state
  );
endinterface

// File: rtl/intc_sched.sv
// Prioritising interrupt controller: synchronises, latches and masks NSRC requests and
// hands the lowest-index one to the CPU. Define INTC_NEST_EN for nested (preemptive) service.
module intc_sched #(
  parameter int NSRC        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       sys_rstn,
  intc_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, INSERV = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] prev_q, pend_q, pend_d, mask_q, edge_q;
  logic [NSRC-1:0] s, rise, elig, w1c, top_oh;
  logic [4:0]      top, srv_id;
  logic            has_elig, wr_pend, wr_mask, wr_edge, vec_rd, eoi, ack;
  logic [31:0]     vec_rdata;
  logic            unused_wd;

  function automatic logic [4:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (v[i]) lowest_idx = 5'(i);
  endfunction

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~prev_q;
  assign elig     = pend_q & mask_q;
  assign has_elig = |elig;
  assign top      = lowest_idx(elig);

  assign wr_pend = bus.sel & bus.we & (bus.addr == 2'd0);
  assign wr_mask = bus.sel & bus.we & (bus.addr == 2'd1);
  assign wr_edge = bus.sel & bus.we & (bus.addr == 2'd2);
  assign eoi     = bus.sel & bus.we & (bus.addr == 2'd3);
  assign vec_rd  = bus.sel & ~bus.we & (bus.addr == 2'd3);
  assign ack     = vec_rd & (state_q == ASSERT) & has_elig;
  assign w1c     = wr_pend ? bus.wd[NSRC-1:0] : '0;
  assign unused_wd = ^bus.wd[31:NSRC];

  always_comb begin
    top_oh = '0;
    for (int i = 0; i < NSRC; i++) top_oh[i] = ack && (top == 5'(i));
  end

  // Edge sources: a rising edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (edge_q[i]) pend_d[i] = rise[i] | (pend_q[i] & ~(w1c[i] | top_oh[i]));
      else           pend_d[i] = s[i];
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '1;
    end else begin
      sync_q[0] <= bus.src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s;
      pend_q <= pend_d;
      if (wr_mask) mask_q <= bus.wd[NSRC-1:0];
      if (wr_edge) edge_q <= bus.wd[NSRC-1:0];
    end
  end

`ifdef INTC_NEST_EN
  logic [NSRC-1:0] isv_q, isv_d, isv_low_oh;
  logic [4:0]      isv_top;

  assign isv_top = lowest_idx(isv_q);
  assign srv_id  = isv_top;

  always_comb begin
    isv_low_oh = '0;
    for (int i = 0; i < NSRC; i++) isv_low_oh[i] = isv_q[i] && (isv_top == 5'(i));
  end

  always_comb begin
    state_d = state_q;
    isv_d   = isv_q;
    case (state_q)
      IDLE:   if (has_elig) state_d = ASSERT;
      ASSERT: begin
        if (!has_elig) begin
          state_d = (isv_q != '0) ? INSERV : IDLE;
        end else if (vec_rd) begin
          state_d = INSERV;
          isv_d   = isv_q | top_oh;
        end
      end
      INSERV: begin
        if (eoi) begin
          isv_d   = isv_q & ~isv_low_oh;
          state_d = (isv_d == '0) ? IDLE : INSERV;
        end else if (has_elig && (top < isv_top)) begin
          state_d = ASSERT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= IDLE;
      isv_q   <= '0;
    end else begin
      state_q <= state_d;
      isv_q   <= isv_d;
    end
  end
`else
  logic [4:0] cur_id_q, cur_id_d;

  assign srv_id = cur_id_q;

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      IDLE:   if (has_elig) state_d = ASSERT;
      ASSERT: begin
        if (!has_elig) begin
          state_d = IDLE;
        end else if (vec_rd) begin
          state_d  = INSERV;
          cur_id_d = top;
        end
      end
      INSERV: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
    end
  end
`endif

  always_comb begin
    vec_rdata = '0;
    case (state_q)
      ASSERT:  if (has_elig) vec_rdata = {1'b1, 26'b0, top};
      INSERV:  vec_rdata = {1'b1, 26'b0, srv_id};
      default: vec_rdata = '0;
    endcase
  end

  always_comb begin
    case (bus.addr)
      2'd0:    bus.rd = {{(32-NSRC){1'b0}}, pend_q};
      2'd1:    bus.rd = {{(32-NSRC){1'b0}}, mask_q};
      2'd2:    bus.rd = {{(32-NSRC){1'b0}}, edge_q};
      default: bus.rd = vec_rdata;
    endcase
  end

  assign bus.irq       = (state_q == ASSERT);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_intc_sched.sv
// Directed bench for intc_sched: hand-computed register, VEC and irq values at each step.
module tb_intc_sched;
  localparam int NSRC = 6;

  logic clk;
  logic rstn;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] v;

  intc_sched_if #(.NSRC(NSRC)) bus_if ();

  intc_sched #(.NSRC(NSRC), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .sys_rstn (rstn),
    .bus      (bus_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks; every task leaves time 1 unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    bus_if.sel  = 1'b0;
    bus_if.addr = a;
    #1 d = bus_if.rd;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.sel  = 1'b1;
    bus_if.we   = 1'b1;
    bus_if.addr = a;
    bus_if.wd   = d;
    tick(1);
    bus_if.sel  = 1'b0;
    bus_if.we   = 1'b0;
  endtask

  task automatic vec_ack(input string tag, input logic [31:0] exp);
    bus_if.sel  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = 2'd3;
    #1 check(tag, bus_if.rd, exp);
    tick(1);
    bus_if.sel  = 1'b0;
  endtask

  task automatic pulse_src(input int idx);
    bus_if.src[idx] = 1'b1;
    tick(1);
    bus_if.src[idx] = 1'b0;
  endtask

  // Directed sequence
  initial begin
    rstn        = 1'b0;
    bus_if.src  = '0;
    bus_if.addr = '0;
    bus_if.sel  = 1'b0;
    bus_if.we   = 1'b0;
    bus_if.wd   = '0;
    tick(2);
    peek(2'd0, v); check("rst_pend", v, 32'h0);
    peek(2'd1, v); check("rst_mask", v, 32'h0);
    peek(2'd2, v); check("rst_edge", v, 32'h3F);
    peek(2'd3, v); check("rst_vec", v, 32'h0);
    check("rst_irq", {31'b0, bus_if.irq}, 32'h0);
    check("rst_state", {30'b0, bus_if.dbg_state}, 32'h0);
    rstn = 1'b1;
    tick(2);

    // Single edge request on src[3]
    bus_write(2'd1, 32'h3F);
    pulse_src(3);
    tick(2);
    peek(2'd0, v); check("t1_pend", v, 32'h08);
    check("t1_irq_pre", {31'b0, bus_if.irq}, 32'h0);
    tick(1);
    check("t1_irq", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t1_ack", 32'h8000_0003);
    peek(2'd0, v); check("t1_pend_clr", v, 32'h0);
    check("t1_irq_srv", {31'b0, bus_if.irq}, 32'h0);
    peek(2'd3, v); check("t1_vec_srv", v, 32'h8000_0003);
    bus_write(2'd3, 32'h0);
    peek(2'd3, v); check("t1_vec_eoi", v, 32'h0);
    tick(2);
    check("t1_irq_idle", {31'b0, bus_if.irq}, 32'h0);

    // Simultaneous src[4] and src[1]: lower index first
    bus_if.src[4] = 1'b1;
    bus_if.src[1] = 1'b1;
    tick(4);
    check("t2_irq", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t2_ack1", 32'h8000_0001);
    peek(2'd0, v); check("t2_pend", v, 32'h10);
    bus_write(2'd3, 32'h0);
    tick(1);
    check("t2_irq_re", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t2_ack4", 32'h8000_0004);
    bus_write(2'd3, 32'h0);
    bus_if.src = '0;
    tick(2);
    check("t2_irq_done", {31'b0, bus_if.irq}, 32'h0);

    // Level mode on src[2]
    bus_write(2'd2, 32'h0);
    bus_if.src[2] = 1'b1;
    tick(4);
    check("t3_irq", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t3_ack", 32'h8000_0002);
    peek(2'd0, v); check("t3_pend_lvl", v, 32'h04);
    bus_write(2'd3, 32'h0);
    tick(1);
    check("t3_irq_re", {31'b0, bus_if.irq}, 32'h1);
    bus_if.src[2] = 1'b0;
    tick(4);
    peek(2'd0, v); check("t3_pend_drop", v, 32'h0);
    check("t3_irq_drop", {31'b0, bus_if.irq}, 32'h0);
    bus_write(2'd2, 32'h3F);

    // Masked request, late enable, W1C while asserted
    bus_write(2'd1, 32'h0);
    pulse_src(0);
    tick(2);
    peek(2'd0, v); check("t4_pend", v, 32'h01);
    tick(2);
    check("t4_irq_masked", {31'b0, bus_if.irq}, 32'h0);
    bus_write(2'd1, 32'h01);
    check("t4_irq_wr", {31'b0, bus_if.irq}, 32'h0);
    tick(1);
    check("t4_irq_en", {31'b0, bus_if.irq}, 32'h1);
    bus_write(2'd0, 32'h01);
    peek(2'd0, v); check("t4_pend_w1c", v, 32'h0);
    tick(1);
    check("t4_irq_w1c", {31'b0, bus_if.irq}, 32'h0);

    // Reset while in service
    bus_write(2'd1, 32'h3F);
    pulse_src(5);
    tick(3);
    vec_ack("t5_ack", 32'h8000_0005);
    check("t5_state_srv", {30'b0, bus_if.dbg_state}, 32'h2);
    #2 rstn = 1'b0;
    #1 check("t5_irq_rst", {31'b0, bus_if.irq}, 32'h0);
    peek(2'd1, v); check("t5_mask_rst", v, 32'h0);
    peek(2'd3, v); check("t5_vec_rst", v, 32'h0);
    check("t5_state_rst", {30'b0, bus_if.dbg_state}, 32'h0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    pulse_src(1);
    tick(5);
    peek(2'd0, v); check("t5_pend_post", v, 32'h02);
    check("t5_irq_post", {31'b0, bus_if.irq}, 32'h0);
    bus_write(2'd1, 32'h02);
    tick(1);
    check("t5_irq_unmask", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t5_ack2", 32'h8000_0001);
    bus_write(2'd3, 32'h0);

    // Higher-priority request arriving during service of src[4]
    bus_write(2'd1, 32'h3F);
    pulse_src(4);
    tick(3);
    vec_ack("t6_ack4", 32'h8000_0004);
    pulse_src(0);
    tick(3);
`ifdef INTC_NEST_EN
    check("t6_irq_pre", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t6_ack0", 32'h8000_0000);
    check("t6_irq_srv", {31'b0, bus_if.irq}, 32'h0);
    bus_write(2'd3, 32'h0);
    peek(2'd3, v); check("t6_vec_outer", v, 32'h8000_0004);
    check("t6_irq_outer", {31'b0, bus_if.irq}, 32'h0);
    bus_write(2'd3, 32'h0);
    check("t6_state_idle", {30'b0, bus_if.dbg_state}, 32'h0);
    peek(2'd3, v); check("t6_vec_idle", v, 32'h0);
`else
    check("t6_irq_nopre", {31'b0, bus_if.irq}, 32'h0);
    peek(2'd3, v); check("t6_vec_srv", v, 32'h8000_0004);
    peek(2'd0, v); check("t6_pend_wait", v, 32'h01);
    bus_write(2'd3, 32'h0);
    tick(1);
    check("t6_irq_next", {31'b0, bus_if.irq}, 32'h1);
    vec_ack("t6_ack0", 32'h8000_0000);
    bus_write(2'd3, 32'h0);
    check("t6_state_idle", {30'b0, bus_if.dbg_state}, 32'h0);
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
